// File: rtl/mul_unit_pkg.sv
// Shared constants and helpers for the multiply functional unit.
package mul_unit_pkg;

  // Functional-unit codes attached to issued ops.
  typedef enum logic [1:0] {
    FU_ALUMISC = 2'b00,
    FU_MEM     = 2'b01,
    FU_MUL     = 2'b10,
    FU_NONE    = 2'b11
  } fu_e;

  // RV32M multiply variants (funct3). Codes 1xx are divide ops, never valid here.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // Decode constants used by the issue stage to route ops here.
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic rega_signed(input logic [2:0] funct3);
    return (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
  endfunction

  // rs2 is treated as signed for MULH only.
  function automatic logic regb_signed(input logic [2:0] funct3);
    return (funct3 == F3_MULH);
  endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Issue / writeback / status signals between the multiply unit and its neighbours.
interface mul_unit_if #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 3
);
  localparam int INFL_W = $clog2(LATENCY + 1);

  // Issue side
  logic              iss_mul_oper;
  logic [XLEN-1:0]   iss_ex_rega;
  logic [XLEN-1:0]   iss_ex_regb;
  logic [2:0]        iss_mul_funct3;
  logic [4:0]        iss_ex_regdest;
  logic              iss_ex_writereg;

  // Writeback side
  logic              wb_mul_grant;
  logic              mul_wb_valid;
  logic [XLEN-1:0]   mul_wb_data;
  logic [4:0]        mul_wb_regdest;
  logic              mul_wb_writereg;

  // Status back to issue
  logic              mul_iss_busy;
  logic [INFL_W-1:0] mul_inflight;
  logic              mul_err_drop;

  // Issue/writeback environment driving the unit.
  modport master (
    output iss_mul_oper, iss_ex_rega, iss_ex_regb, iss_mul_funct3,
           iss_ex_regdest, iss_ex_writereg, wb_mul_grant,
    input  mul_wb_valid, mul_wb_data, mul_wb_regdest, mul_wb_writereg,
           mul_iss_busy, mul_inflight, mul_err_drop
  );

  // The multiply unit itself.
  modport slave (
    input  iss_mul_oper, iss_ex_rega, iss_ex_regb, iss_mul_funct3,
           iss_ex_regdest, iss_ex_writereg, wb_mul_grant,
    output mul_wb_valid, mul_wb_data, mul_wb_regdest, mul_wb_writereg,
           mul_iss_busy, mul_inflight, mul_err_drop
  );

endinterface

// File: rtl/mul_unit_stage_reg.sv
// One pipeline stage: valid bit plus opaque payload, held when en is low.
module mul_stage_reg #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         d_valid,
  input  logic [W-1:0] d_payload,
  output logic         q_valid,
  output logic [W-1:0] q_payload
);

  // Capture on advance; bubbles are held like real ops.
  // NOTE: sequential state uses <= so every stage samples the pre-edge values of its neighbour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_valid   <= 1'b0;
      // NOTE: payload is reset too because the last stage drives the result bus, which must read zero out of reset.
      q_payload <= '0;
    end else if (en) begin
      q_valid   <= d_valid;
      q_payload <= d_payload;
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Pipelined RV32M multiply unit with valid/grant writeback and whole-pipe freeze.
import mul_unit_pkg::*;

module mul_unit #(
  parameter int LATENCY = 3,
  parameter int XLEN    = 32
) (
  input  logic     clock,
  input  logic     reset,
  mul_unit_if.slave bus
);

  localparam int INFL_W = $clog2(LATENCY + 1);

  // Stage 1 payload: extended operands and op metadata.
  typedef struct packed {
    logic [XLEN:0] a;
    logic [XLEN:0] b;
    logic [2:0]    funct3;
    logic [4:0]    regdest;
    logic          writereg;
  } op_t;

  // Stage 2..LATENCY payload: selected result.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      regdest;
    logic            writereg;
  } res_t;

  logic              advance;
  logic              accept;
  logic              retire;
  op_t               op_d;
  op_t               s1_q;
  logic              s1_v;
  res_t              sel_d;
  logic [LATENCY:2]  rv;
  res_t [LATENCY:2]  rq;
  logic [2*XLEN-1:0] a_x;
  logic [2*XLEN-1:0] b_x;
  logic [2*XLEN-1:0] prod;
  logic [INFL_W-1:0] inflight;
  logic              err_drop;

  // The pipe moves only when the output register is empty or being taken.
  assign advance = !(rv[LATENCY] && !bus.wb_mul_grant);
  assign accept  = bus.iss_mul_oper && advance;
  assign retire  = rv[LATENCY] && bus.wb_mul_grant;

  // Extend operands to 33 bits according to the variant's signedness.
  always_comb begin
    op_d          = '0;
    op_d.a        = rega_signed(bus.iss_mul_funct3) ? {bus.iss_ex_rega[XLEN-1], bus.iss_ex_rega}
                                                    : {1'b0, bus.iss_ex_rega};
    op_d.b        = regb_signed(bus.iss_mul_funct3) ? {bus.iss_ex_regb[XLEN-1], bus.iss_ex_regb}
                                                    : {1'b0, bus.iss_ex_regb};
    op_d.funct3   = bus.iss_mul_funct3;
    op_d.regdest  = bus.iss_ex_regdest;
    op_d.writereg = bus.iss_ex_writereg;
  end

  // Multiply and select between stage 1 and stage 2. Only the low 64 bits of
  // the 66-bit signed product are ever selected, so operands are sign-extended
  // to 64 bits and the product is truncated there.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    sel_d         = '0;
    a_x           = {{(XLEN-1){s1_q.a[XLEN]}}, s1_q.a};
    b_x           = {{(XLEN-1){s1_q.b[XLEN]}}, s1_q.b};
    prod          = a_x * b_x;
    sel_d.regdest = s1_q.regdest;
    case (s1_q.funct3)
      F3_MUL: begin
        sel_d.data     = prod[XLEN-1:0];
        sel_d.writereg = s1_q.writereg;
      end
      F3_MULH, F3_MULHSU, F3_MULHU: begin
        sel_d.data     = prod[2*XLEN-1:XLEN];
        sel_d.writereg = s1_q.writereg;
      end
      default: begin
        sel_d.data     = '0;
        sel_d.writereg = 1'b0;
      end
    endcase
  end

  // Stage chain: stage 1 holds operands, later stages carry the result.
  for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
    if (k == 1) begin : g_op
      mul_stage_reg #(.W($bits(op_t))) u_reg (
        .clock     (clock),
        .reset     (reset),
        .en        (advance),
        .d_valid   (bus.iss_mul_oper),
        .d_payload (op_d),
        .q_valid   (s1_v),
        .q_payload (s1_q)
      );
    end else if (k == 2) begin : g_sel
      mul_stage_reg #(.W($bits(res_t))) u_reg (
        .clock     (clock),
        .reset     (reset),
        .en        (advance),
        .d_valid   (s1_v),
        .d_payload (sel_d),
        .q_valid   (rv[k]),
        .q_payload (rq[k])
      );
    end else begin : g_res
      mul_stage_reg #(.W($bits(res_t))) u_reg (
        .clock     (clock),
        .reset     (reset),
        .en        (advance),
        .d_valid   (rv[k-1]),
        .d_payload (rq[k-1]),
        .q_valid   (rv[k]),
        .q_payload (rq[k])
      );
    end
  end

  // Track ops between accept and retire; simultaneous accept/retire cancels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   inflight <= inflight + INFL_W'(1);
        2'b01:   inflight <= inflight - INFL_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky flag for ops offered while the pipe was frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_drop <= 1'b0;
    end else if (bus.iss_mul_oper && !advance) begin
      err_drop <= 1'b1;
    end
  end

  assign bus.mul_wb_valid    = rv[LATENCY];
  assign bus.mul_wb_data     = rq[LATENCY].data;
  assign bus.mul_wb_regdest  = rq[LATENCY].regdest;
  assign bus.mul_wb_writereg = rq[LATENCY].writereg;
  assign bus.mul_iss_busy    = !advance;
  assign bus.mul_inflight    = inflight;
  assign bus.mul_err_drop    = err_drop;

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Pipelined multiply functional unit directly downstream of the issue stage.
- Consumes ops tagged for the multiply unit (unit code 2'b10) together with their latched operands and destination.
- Computes the RV32M MUL/MULH/MULHSU/MULHU results and presents them to the writeback arbiter with a valid/grant handshake.
- Freezes the whole pipe under writeback backpressure and reports busy and in-flight status back to issue.

Parameters:
- LATENCY, 3, number of register stages from operand capture to the output register (min 2).
- XLEN, 32, operand and result width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- iss_mul_oper  in  1  op present this cycle for the multiply unit
- iss_ex_rega  in  XLEN  rs1 value
- iss_ex_regb  in  XLEN  rs2 value
- iss_mul_funct3  in  3  multiply variant select
- iss_ex_regdest  in  5  destination register
- iss_ex_writereg  in  1  op writes the register file
- wb_mul_grant  in  1  writeback accepts the current output this cycle
- mul_wb_valid  out  1  output register holds a result
- mul_wb_data  out  XLEN  result
- mul_wb_regdest  out  5  destination of the result
- mul_wb_writereg  out  1  result must be written
- mul_iss_busy  out  1  unit cannot accept an op this cycle
- mul_inflight  out  clog2(LATENCY+1)  number of valid ops in the pipe
- mul_err_drop  out  1  sticky flag: an op arrived while busy and was dropped

Behaviour:
- Reset (async, active-high): all stage valids 0; mul_wb_valid, mul_wb_data, mul_wb_regdest, mul_wb_writereg = 0; mul_inflight = 0; mul_err_drop = 0. Reset asserted mid-operation discards every in-flight op; nothing is retired.
- Advance condition: advance = !(mul_wb_valid && !wb_mul_grant).
  - advance=1: every stage shifts one step.
  - advance=0: every stage holds, including bubbles (no bubble collapse).
- mul_iss_busy = !advance; combinational.
- Accept: op accepted at an edge when iss_mul_oper=1 and advance=1.
  - Stage 1 captures 33-bit extended operands, funct3, regdest, writereg, valid=1.
  - iss_mul_oper=0 with advance=1 loads a bubble (valid=0).
- Drop: iss_mul_oper=1 with advance=0 drops the op; mul_err_drop sets and holds until reset.
- Latency: op with iss_mul_oper high in cycle c (sampled at the edge ending c) produces mul_wb_valid=1 in cycle c+LATENCY, with no backpressure. Full throughput: one op per cycle.
- Operand extension:
  - rega: signed for 001/010; zero-extended for 011 and 000.
  - regb: signed for 001 only.
  - 000 uses either extension, since the low half is identical.
- The 66-bit product is formed in stage 1→2. Later stages carry the 64-bit product or the selected result.
- Result selection (funct3):
  - 000 MUL: product[31:0].
  - 001 MULH, 010 MULHSU, 011 MULHU: product[63:32].
  - 1xx: data=0, writereg forced 0; the op still retires with valid.
- Output: mul_wb_* driven from the last stage register.
  - An op retires on the edge where mul_wb_valid && wb_mul_grant.
  - The output holds stable while valid && !grant.
  - wb_mul_grant while !mul_wb_valid is ignored.
- mul_inflight: +1 on accept, −1 on retire, unchanged when both occur on the same edge. Never exceeds LATENCY. A dropped op does not count.
- Destination x0: passes through unchanged; writeback filters it.

Decomposition:
- Shared package:
  - FU code constants: ALUMISC=2'b00, MEM=2'b01, MUL=2'b10, NONE=2'b11.
  - funct3 constants: MUL=3'b000, MULH=3'b001, MULHSU=3'b010, MULHU=3'b011.
  - RV opcode constant OP=7'b0110011 and funct7 MULDIV=7'b0000001.
- Sub-module mul_stage_reg: one pipeline stage register with valid, payload and hold enable. Instantiated LATENCY times via generate; the product/select logic sits between stages 1 and 2.

Test Plan:
1. Reset, then MUL with rega=7, regb=0xFFFFFFFD, regdest=5, writereg=1 in cycle 0, grant=1 → cycle 3: valid=1, data=0xFFFFFFEB, regdest=5; inflight 1 in cycles 1–3, 0 after.
2. Back-to-back ops on cycles 0–3, grant=1:
   - MULH 0x80000000×0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
   - funct3=3'b100 → data 0, writereg 0.
   - Required response: results appear on cycles 3–6 in order; inflight peaks at 3.
3. Three ops issued, grant=0 from cycle 3 to 6 → busy=1 in cycles 3–6; output stable; inflight=3; grant=1 in cycle 7 → ops retire on cycles 7, 8, 9.
4. iss_mul_oper=1 while busy=1 → op never appears; mul_err_drop=1 until reset; inflight unchanged.
5. Reset pulsed in cycle 1 with two ops in flight → all outputs 0, inflight 0, no valid for the following LATENCY+2 cycles.
